ctrl_pipe_hazard: RTL and testbench

//  Pipelines the decode-stage controller outputs through the EX, MEM and WB stages of the
//  5-stage RISC-V core. Resolves branch/jump in EX to produce pcsrc. Detects load-use hazards,

---
 rtl/ctrl_pipe_hazard.sv | 194 +++++++++++++++++++
 tb/tb_ctrl_pipe_hazard.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipe_hazard.sv
//------------------------------------------------------------------------------
// Module   : ctrl_pipe_hazard
// Brief    : EX/MEM/WB control pipeline with branch resolution, load-use
//            hazard detection, stall/flush generation and EX forwarding selects.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ctrl_pipe_hazard #(
    parameter int RA_W   = 5,
    parameter int ALUC_W = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_d,
    input  logic              reg_write_d,
    input  logic              mem_write_d,
    input  logic [1:0]        result_src_d,
    input  logic              alu_src_d,
    input  logic [ALUC_W-1:0] alu_control_d,
    input  logic              branch_d,
    input  logic              branch_neg_d,
    input  logic              jump_d,
    input  logic              jalr_d,
    input  logic [RA_W-1:0]   rs1_d,
    input  logic [RA_W-1:0]   rs2_d,
    input  logic [RA_W-1:0]   rd_d,
    input  logic              zero_e,
    output logic              alu_src_e,
    output logic [ALUC_W-1:0] alu_control_e,
    output logic              mem_write_m,
    output logic [1:0]        result_src_w,
    output logic              reg_write_w,
    output logic [RA_W-1:0]   rd_e,
    output logic [RA_W-1:0]   rd_m,
    output logic [RA_W-1:0]   rd_w,
    output logic [1:0]        pcsrc_e,
    output logic              stall_f,
    output logic              stall_d,
    output logic              flush_d,
    output logic              flush_e,
    output logic [1:0]        forward_a_e,
    output logic [1:0]        forward_b_e
);

    localparam logic [1:0] c_RES_LOAD = 2'b01;
    localparam logic [1:0] c_FWD_NONE = 2'b00;
    localparam logic [1:0] c_FWD_WB   = 2'b01;
    localparam logic [1:0] c_FWD_MEM  = 2'b10;
    localparam logic [1:0] c_PC_PLUS4 = 2'b00;
    localparam logic [1:0] c_PC_IMM   = 2'b01;
    localparam logic [1:0] c_PC_ALU   = 2'b10;

    // EX stage
    logic              r_valid_e;
    logic              r_reg_write_e;
    logic              r_mem_write_e;
    logic [1:0]        r_result_src_e;
    logic              r_alu_src_e;
    logic [ALUC_W-1:0] r_alu_control_e;
    logic              r_branch_e;
    logic              r_branch_neg_e;
    logic              r_jump_e;
    logic              r_jalr_e;
    logic [RA_W-1:0]   r_rs1_e;
    logic [RA_W-1:0]   r_rs2_e;
    logic [RA_W-1:0]   r_rd_e;

    // MEM stage
    logic              r_reg_write_m;
    logic              r_mem_write_m;
    logic [1:0]        r_result_src_m;
    logic [RA_W-1:0]   r_rd_m;

    // WB stage
    logic              r_reg_write_w;
    logic [1:0]        r_result_src_w;
    logic [RA_W-1:0]   r_rd_w;

    logic              w_taken_e;
    logic              w_lw_stall;
    logic              w_flush_e;
    logic              w_load_e;
    logic [1:0]        w_pcsrc_e;
    logic [1:0]        w_fwd_a;
    logic [1:0]        w_fwd_b;

    assign w_taken_e  = r_valid_e & (r_jump_e | r_jalr_e |
                                     (r_branch_e & (zero_e ^ r_branch_neg_e)));
    assign w_lw_stall = r_valid_e & (r_result_src_e == c_RES_LOAD) &
                        (r_rd_e != '0) & valid_d &
                        ((rs1_d == r_rd_e) | (rs2_d == r_rd_e));
    assign w_flush_e  = w_lw_stall | w_taken_e;
    // A bubble enters EX either because D holds no instruction or because
    // the ID/EX register is being flushed; all E controls clear together.
    assign w_load_e   = valid_d & ~w_flush_e;

    always_comb begin
        w_pcsrc_e = c_PC_PLUS4;
        if (r_jalr_e) begin
            w_pcsrc_e = c_PC_ALU;
        end else if (w_taken_e) begin
            w_pcsrc_e = c_PC_IMM;
        end
    end

    // MEM result is younger than WB, so it takes priority.
    always_comb begin
        w_fwd_a = c_FWD_NONE;
        w_fwd_b = c_FWD_NONE;
        if (r_reg_write_m && (r_rd_m != '0) && (r_rd_m == r_rs1_e)) begin
            w_fwd_a = c_FWD_MEM;
        end else if (r_reg_write_w && (r_rd_w != '0) && (r_rd_w == r_rs1_e)) begin
            w_fwd_a = c_FWD_WB;
        end
        if (r_reg_write_m && (r_rd_m != '0) && (r_rd_m == r_rs2_e)) begin
            w_fwd_b = c_FWD_MEM;
        end else if (r_reg_write_w && (r_rd_w != '0) && (r_rd_w == r_rs2_e)) begin
            w_fwd_b = c_FWD_WB;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !w_load_e) begin
            r_valid_e       <= 1'b0;
            r_reg_write_e   <= 1'b0;
            r_mem_write_e   <= 1'b0;
            r_result_src_e  <= '0;
            r_alu_src_e     <= 1'b0;
            r_alu_control_e <= '0;
            r_branch_e      <= 1'b0;
            r_branch_neg_e  <= 1'b0;
            r_jump_e        <= 1'b0;
            r_jalr_e        <= 1'b0;
            r_rs1_e         <= '0;
            r_rs2_e         <= '0;
            r_rd_e          <= '0;
        end else begin
            r_valid_e       <= 1'b1;
            r_reg_write_e   <= reg_write_d;
            r_mem_write_e   <= mem_write_d;
            r_result_src_e  <= result_src_d;
            r_alu_src_e     <= alu_src_d;
            r_alu_control_e <= alu_control_d;
            r_branch_e      <= branch_d;
            r_branch_neg_e  <= branch_neg_d;
            r_jump_e        <= jump_d;
            r_jalr_e        <= jalr_d;
            r_rs1_e         <= rs1_d;
            r_rs2_e         <= rs2_d;
            r_rd_e          <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_reg_write_m  <= 1'b0;
            r_mem_write_m  <= 1'b0;
            r_result_src_m <= '0;
            r_rd_m         <= '0;
            r_reg_write_w  <= 1'b0;
            r_result_src_w <= '0;
            r_rd_w         <= '0;
        end else begin
            r_reg_write_m  <= r_reg_write_e;
            r_mem_write_m  <= r_mem_write_e;
            r_result_src_m <= r_result_src_e;
            r_rd_m         <= r_rd_e;
            r_reg_write_w  <= r_reg_write_m;
            r_result_src_w <= r_result_src_m;
            r_rd_w         <= r_rd_m;
        end
    end

    assign alu_src_e     = r_alu_src_e;
    assign alu_control_e = r_alu_control_e;
    assign mem_write_m   = r_mem_write_m;
    assign result_src_w  = r_result_src_w;
    assign reg_write_w   = r_reg_write_w;
    assign rd_e          = r_rd_e;
    assign rd_m          = r_rd_m;
    assign rd_w          = r_rd_w;
    assign pcsrc_e       = w_pcsrc_e;
    // A redirect discards the dependent instruction, so it overrides the stall.
    assign stall_f       = w_lw_stall & ~w_taken_e;
    assign stall_d       = w_lw_stall & ~w_taken_e;
    assign flush_d       = w_taken_e;
    assign flush_e       = w_flush_e;
    assign forward_a_e   = w_fwd_a;
    assign forward_b_e   = w_fwd_b;

endmodule

`default_nettype wire

// File: tb/tb_ctrl_pipe_hazard.sv
//------------------------------------------------------------------------------
// Module   : tb_ctrl_pipe_hazard
// Brief    : Scoreboard bench for ctrl_pipe_hazard against a per-instruction
//            pipeline reference model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ctrl_pipe_hazard;

    typedef struct packed {
        logic       valid;
        logic       rw;
        logic       mw;
        logic [1:0] rsrc;
        logic       asrc;
        logic [2:0] aluc;
        logic       br;
        logic       bneg;
        logic       j;
        logic       jr;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
    } instr_t;

    typedef struct packed {
        logic       alu_src_e;
        logic [2:0] alu_control_e;
        logic       mem_write_m;
        logic [1:0] result_src_w;
        logic       reg_write_w;
        logic [4:0] rd_e;
        logic [4:0] rd_m;
        logic [4:0] rd_w;
        logic [1:0] pcsrc_e;
        logic       stall_f;
        logic       stall_d;
        logic       flush_d;
        logic       flush_e;
        logic [1:0] fa;
        logic [1:0] fb;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       valid_d = 1'b0, reg_write_d = 1'b0, mem_write_d = 1'b0;
    logic [1:0] result_src_d = '0;
    logic       alu_src_d = 1'b0;
    logic [2:0] alu_control_d = '0;
    logic       branch_d = 1'b0, branch_neg_d = 1'b0, jump_d = 1'b0, jalr_d = 1'b0;
    logic [4:0] rs1_d = '0, rs2_d = '0, rd_d = '0;
    logic       zero_e = 1'b0;
    logic       alu_src_e;
    logic [2:0] alu_control_e;
    logic       mem_write_m;
    logic [1:0] result_src_w;
    logic       reg_write_w;
    logic [4:0] rd_e, rd_m, rd_w;
    logic [1:0] pcsrc_e;
    logic       stall_f, stall_d, flush_d, flush_e;
    logic [1:0] forward_a_e, forward_b_e;

    ctrl_pipe_hazard #(.RA_W(5), .ALUC_W(3)) dut (
        .clk(clk), .reset(reset), .valid_d(valid_d), .reg_write_d(reg_write_d),
        .mem_write_d(mem_write_d), .result_src_d(result_src_d), .alu_src_d(alu_src_d),
        .alu_control_d(alu_control_d), .branch_d(branch_d), .branch_neg_d(branch_neg_d),
        .jump_d(jump_d), .jalr_d(jalr_d), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
        .zero_e(zero_e), .alu_src_e(alu_src_e), .alu_control_e(alu_control_e),
        .mem_write_m(mem_write_m), .result_src_w(result_src_w), .reg_write_w(reg_write_w),
        .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w), .pcsrc_e(pcsrc_e), .stall_f(stall_f),
        .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
        .forward_a_e(forward_a_e), .forward_b_e(forward_b_e)
    );

    always #5 clk = ~clk;

    int     checks = 0;
    int     errors = 0;
    exp_t   q[$];

    // Reference model: the instruction occupying each stage (0=E, 1=M, 2=W).
    instr_t stage [3];
    instr_t prev_d;
    logic   prev_rst = 1'b1;
    logic   prev_flush_e = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] fwd(input logic [4:0] r);
        if (stage[1].rw && stage[1].rd != 0 && stage[1].rd == r) return 2'd2;
        if (stage[2].rw && stage[2].rd != 0 && stage[2].rd == r) return 2'd1;
        return 2'd0;
    endfunction

    // One clock: retire the previous cycle into the model, present new inputs,
    // and queue what the DUT must show during this cycle.
    task automatic cycle(input instr_t d, input logic z, input logic rst);
        exp_t e;
        logic taken, lw;
        @(posedge clk);
        #1;
        if (prev_rst) begin
            for (int i = 0; i < 3; i++) stage[i] = '0;
        end else begin
            stage[2] = stage[1];
            stage[1] = stage[0];
            stage[0] = (prev_flush_e || !prev_d.valid) ? instr_t'(0) : prev_d;
        end
        if (!d.valid) begin
            d.rs1 = 0; d.rs2 = 0; d.rd = 0;
        end
        reset = rst; valid_d = d.valid; reg_write_d = d.rw; mem_write_d = d.mw;
        result_src_d = d.rsrc; alu_src_d = d.asrc; alu_control_d = d.aluc;
        branch_d = d.br; branch_neg_d = d.bneg; jump_d = d.j; jalr_d = d.jr;
        rs1_d = d.rs1; rs2_d = d.rs2; rd_d = d.rd; zero_e = z;

        taken = stage[0].valid && (stage[0].j || stage[0].jr ||
                (stage[0].br && (z != stage[0].bneg)));
        lw = stage[0].valid && stage[0].rsrc == 2'b01 && stage[0].rd != 0 &&
             d.valid && (d.rs1 == stage[0].rd || d.rs2 == stage[0].rd);
        e.alu_src_e     = stage[0].asrc;
        e.alu_control_e = stage[0].aluc;
        e.mem_write_m   = stage[1].mw;
        e.result_src_w  = stage[2].rsrc;
        e.reg_write_w   = stage[2].rw;
        e.rd_e = stage[0].rd;
        e.rd_m = stage[1].rd;
        e.rd_w = stage[2].rd;
        e.pcsrc_e = (stage[0].valid && stage[0].jr) ? 2'd2 : (taken ? 2'd1 : 2'd0);
        e.stall_f = lw && !taken;
        e.stall_d = lw && !taken;
        e.flush_d = taken;
        e.flush_e = lw || taken;
        e.fa = fwd(stage[0].rs1);
        e.fb = fwd(stage[0].rs2);
        q.push_back(e);
        prev_d = d;
        prev_rst = rst;
        prev_flush_e = e.flush_e;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("alu_src_e", alu_src_e, e.alu_src_e);
                chk("alu_control_e", alu_control_e, e.alu_control_e);
                chk("mem_write_m", mem_write_m, e.mem_write_m);
                chk("result_src_w", result_src_w, e.result_src_w);
                chk("reg_write_w", reg_write_w, e.reg_write_w);
                chk("rd_e", rd_e, e.rd_e);
                chk("rd_m", rd_m, e.rd_m);
                chk("rd_w", rd_w, e.rd_w);
                chk("pcsrc_e", pcsrc_e, e.pcsrc_e);
                chk("stall_f", stall_f, e.stall_f);
                chk("stall_d", stall_d, e.stall_d);
                chk("flush_d", flush_d, e.flush_d);
                chk("flush_e", flush_e, e.flush_e);
                chk("forward_a_e", forward_a_e, e.fa);
                chk("forward_b_e", forward_b_e, e.fb);
            end
        end
    end

    function automatic logic [4:0] pick_reg();
        case ($urandom_range(0, 4))
            0: return 5'd0;
            1: return 5'd1;
            2: return 5'd2;
            3: return 5'd5;
            default: return 5'd6;
        endcase
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        i.valid = ($urandom_range(0, 99) < 85);
        i.rw    = $urandom_range(0, 1);
        i.mw    = $urandom_range(0, 1);
        i.rsrc  = 2'($urandom_range(0, 2));
        i.asrc  = $urandom_range(0, 1);
        i.aluc  = 3'($urandom_range(0, 7));
        i.br    = ($urandom_range(0, 99) < 20);
        i.bneg  = $urandom_range(0, 1);
        i.j     = ($urandom_range(0, 99) < 8);
        i.jr    = ($urandom_range(0, 99) < 6);
        i.rs1   = pick_reg();
        i.rs2   = pick_reg();
        i.rd    = pick_reg();
        return i;
    endfunction

    function automatic instr_t mk(input logic rw, input logic [1:0] rsrc,
                                  input logic [4:0] rd, input logic [4:0] rs1,
                                  input logic [4:0] rs2);
        instr_t i = '0;
        i.valid = 1'b1; i.rw = rw; i.rsrc = rsrc; i.rd = rd; i.rs1 = rs1; i.rs2 = rs2;
        i.aluc = 3'd2; i.asrc = (rsrc == 2'b01);
        return i;
    endfunction

    instr_t nop, lw5, add6, add5, add7, beq, bne, jalr_ld, wr0, lw0, use0;

    initial begin : driver
        nop  = '0;
        lw5  = mk(1, 2'b01, 5'd5, 5'd1, 5'd0);
        add6 = mk(1, 2'b00, 5'd6, 5'd5, 5'd1);
        add5 = mk(1, 2'b00, 5'd5, 5'd1, 5'd2);
        add7 = mk(1, 2'b00, 5'd7, 5'd5, 5'd5);
        beq  = mk(0, 2'b00, 5'd0, 5'd1, 5'd2); beq.br = 1'b1;
        bne  = beq; bne.bneg = 1'b1;
        jalr_ld = mk(1, 2'b01, 5'd5, 5'd1, 5'd0); jalr_ld.jr = 1'b1;
        wr0  = mk(1, 2'b00, 5'd0, 5'd0, 5'd0);
        lw0  = mk(1, 2'b01, 5'd0, 5'd1, 5'd0);
        use0 = mk(1, 2'b00, 5'd6, 5'd0, 5'd0);

        cycle(nop, 0, 1);
        cycle(nop, 0, 1);
        // load-use stall, then forwarding from WB once the add reaches EX
        cycle(lw5, 0, 0);
        cycle(add6, 0, 0);
        cycle(add6, 0, 0);
        cycle(add6, 0, 0);
        cycle(nop, 0, 0);
        // back-to-back ALU dependence through MEM
        cycle(add5, 0, 0);
        cycle(add7, 0, 0);
        cycle(nop, 0, 0);
        // beq taken, then bne not taken with zero set
        cycle(beq, 0, 0);
        cycle(nop, 1, 0);
        cycle(bne, 0, 0);
        cycle(nop, 1, 0);
        // jalr in EX colliding with a load-use pattern
        cycle(jalr_ld, 0, 0);
        cycle(add6, 0, 0);
        cycle(nop, 0, 0);
        // x0 neither forwards nor stalls
        cycle(wr0, 0, 0);
        cycle(use0, 0, 0);
        cycle(lw0, 0, 0);
        cycle(use0, 0, 0);
        cycle(nop, 0, 0);
        // reset with writers in every stage
        cycle(add5, 0, 0);
        cycle(add6, 0, 0);
        cycle(add7, 0, 0);
        cycle(add5, 0, 1);
        cycle(nop, 0, 0);

        for (int n = 0; n < 3000; n++) begin
            cycle(rand_instr(), $urandom_range(0, 1), ($urandom_range(0, 199) == 0));
        end

        @(posedge clk);
        @(posedge clk);
        chk("scoreboard_drained", q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
